// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM input-capture block.
package pwm_capture_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  // Consecutive cycles a new level must hold before the glitch filter accepts it.
  localparam int unsigned FILT_LEN      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/pwm_capture_edge.sv
// Synchronises pwm_i and produces registered one-cycle rise/fall pulses.
// Define PWM_CAPTURE_FILTER_EN to insert a glitch filter before edge detection.
module pwm_capture_edge
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk_i,
  input  logic preset_n_i,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   lvl_q;
  logic                   dly_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FiltW = $clog2(FILT_LEN + 1);

  logic [FiltW-1:0] fcnt_q;
  logic             filt_q;

  // Any return to the accepted level restarts the qualification window.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FiltW'(FILT_LEN - 1)) begin
      fcnt_q <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  // Pulses are registered so the FSM only ever sees flop outputs.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      lvl_q  <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= level;
      dly_q  <= lvl_q;
      rise_q <= lvl_q & ~dly_q;
      fall_q <= ~lvl_q & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time, results on valid/ready.
// Define PWM_CAPTURE_FILTER_EN to enable the input glitch filter.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             pclk_i,
  input  logic             preset_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             sat_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_out_q;
  logic             valid_q;
  logic             sat_q;
  logic             overrun_q;
  state_e           state_q;

  pwm_capture_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .pclk_i    (pclk_i),
    .preset_n_i(preset_n_i),
    .pwm_i     (pwm_i),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Later assignments override earlier ones: a publish beats acceptance, set beats clear.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q    <= StIdle;
      high_q     <= '0;
      period_q   <= '0;
      high_out_q <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (clr_i) begin
        sat_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if (!en_i) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            if (rise) begin
              state_q <= StHigh;
            end
          end
          StHigh: begin
            if (cnt_q == CntMax) begin
              sat_q   <= 1'b1;
              state_q <= StArm;
            end else if (fall) begin
              high_q  <= cnt_q;
              state_q <= StLow;
            end
          end
          StLow: begin
            if (cnt_q == CntMax) begin
              sat_q   <= 1'b1;
              state_q <= StArm;
            end else if (rise) begin
              period_q   <= cnt_q;
              high_out_q <= high_q;
              valid_q    <= 1'b1;
              if (valid_q && !ready_i) begin
                overrun_q <= 1'b1;
              end
              state_q <= StHigh;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_out_q;
  assign valid_o   = valid_q;
  assign sat_o     = sat_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture receiver that measures period and high time of an external PWM waveform, clocked in the APB domain.
- Receive-side counterpart of the PWM controller: loops back the controller's pwm_o for self-test, or captures an external PWM/tach signal.
- Results are delivered on a valid/ready interface to a register block or DMA.

Parameters:
- CNT_W, 16, width of the period/high counters and result ports.
- SYNC_STAGES, 2, flops in the pwm_i synchroniser (minimum 2).

Ports:
- pclk_i  input  1  clock.
- preset_n_i  input  1  asynchronous active-low reset.
- en_i  input  1  capture enable; level-sensitive.
- clr_i  input  1  one-cycle pulse; clears sticky flags.
- pwm_i  input  1  asynchronous PWM input.
- period_o  output  CNT_W  captured period in pclk cycles.
- high_o  output  CNT_W  captured high time in pclk cycles.
- valid_o  output  1  result available.
- ready_i  input  1  consumer accepts the result.
- sat_o  output  1  sticky: counter saturated, measurement discarded.
- overrun_o  output  1  sticky: result overwritten while unconsumed.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-low. All outputs and internal state reset to 0; FSM resets to IDLE.
- pwm_i passes through SYNC_STAGES flops, then a one-flop edge detector produces rise/fall pulses from the synchronised signal.
- Counter cnt:
  - Loads 1 on the cycle a rise is detected.
  - Otherwise increments by 1, saturating at 2^CNT_W-1.
- FSM states and transitions:
  - IDLE: en_i=1 -> ARM.
  - ARM: waits for the first rise (ignores the partial period in progress); rise -> HIGH.
  - HIGH: fall -> latch high_q=cnt, go LOW.
  - LOW: rise -> publish period_o=cnt and high_o=high_q, assert valid_o, go HIGH. The same rise starts the next period, so capture runs back-to-back every period.
  - HIGH or LOW with cnt reaching 2^CNT_W-1 (stuck signal, or 0%/100% duty): set sat_o, discard the measurement, go ARM.
- en_i=0 in any state -> IDLE next cycle. cnt and valid_o are cleared; sticky flags are kept.
- Handshake:
  - valid_o stays high until a cycle with valid_o&&ready_i; it drops the following cycle.
  - Outputs are stable while valid_o=1 unless an overrun occurs.
- Overrun: a publish while valid_o=1 and ready_i=0 overwrites period_o/high_o, keeps valid_o=1 and sets overrun_o.
- Simultaneous publish and accept in the same cycle: the new result is loaded, valid_o stays 1, no overrun.
- clr_i clears sat_o/overrun_o. A set event in the same cycle wins.
- Latency: valid_o rises exactly SYNC_STAGES+2 cycles after the pclk edge that first samples pwm_i high for the closing rise.
- Minimum measurable high/low time is 1 cycle after synchronisation; pulses narrower than one pclk period may be missed.
- Reset asserted mid-measurement aborts immediately with no partial result.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A glitch filter sits between the synchroniser and the edge detector.
  - The filtered level changes only after the synchronised input has held the new level for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN are ignored.
  - Latency increases by FILT_LEN; measured values are unchanged for clean input.
- Undefined: no filter, base latency applies.

Decomposition:
- Package pwm_capture_pkg holds:
  - The state enum (IDLE, ARM, HIGH, LOW).
  - Localparam FILT_LEN=3.
  - Default CNT_W.
- Sub-module pwm_capture_edge: synchroniser, optional filter and rise/fall pulse generation.
- The FSM, counter, result registers and flags stay in pwm_capture.

Test Plan:
- Clean PWM, 3 cycles high and 5 low, en_i=1, ready_i=1 -> first result after one ARM period; every period: period_o=8, high_o=3, valid_o pulses once per period.
- Same waveform with ready_i=0 for 2 periods, then 1 -> valid_o held, overrun_o=1, outputs show the latest period; valid_o drops one cycle after acceptance.
- CNT_W=4, pwm_i held high 20 cycles after a rise -> sat_o=1 at cnt=15, FSM returns to ARM, no valid_o; clr_i then clears sat_o.
- Latency check: single clean period -> valid_o rises exactly SYNC_STAGES+2 cycles after the closing rising-edge sample; with the filter macro defined, FILT_LEN cycles later.
- en_i dropped mid-HIGH, then re-raised -> busy_o=0 next cycle, valid_o cleared; after re-enable, the first result requires a full ARM period with no stale high_o.
- Filter build: 2-cycle glitch inside the low phase of an 8/3 waveform -> period_o=8, high_o=3 unaffected. Non-filter build: the glitch yields a short measurement.
